// File: rtl/mac_pe_vec.sv
// Vector multiply-accumulate PE for the systolic CNN array: dot product of LANES
// operand pairs per beat, accumulated until a_last, with operand pass-through.
module mac_pe_vec #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic                    a_last,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [LANES*DATA_W-1:0] b,
  input  logic                    b_valid,
  output logic                    b_ready,
  output logic [LANES*DATA_W-1:0] a_out,
  output logic                    a_out_last,
  output logic                    a_out_valid,
  input  logic                    a_out_ready,
  output logic [LANES*DATA_W-1:0] b_out,
  output logic                    b_out_valid,
  input  logic                    b_out_ready,
  output logic [ACC_W-1:0]        out,
  output logic [CNT_W-1:0]        out_beats,
  output logic                    out_sat,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int VEC_W = LANES * DATA_W;
  localparam int SUM_W = 2 * DATA_W + $clog2(LANES);
  localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam bit SGN   = (SIGNED != 0);
  localparam bit SAT   = (SATURATE != 0);

  localparam logic [ACC_W-1:0] ACC_MAX = SGN ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_MIN = SGN ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};

  logic [VEC_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic             a_out_last_q, a_out_last_d;
  logic             a_out_valid_q, a_out_valid_d, b_out_valid_q, b_out_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_q, out_d;
  logic             sat_q, sat_d, out_sat_q, out_sat_d, out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, out_beats_q, out_beats_d;

  // Handshake: both operands are consumed together; only last beats need the result slot.
  logic a_free, b_free, r_free, go, fire;
  assign a_free  = !a_out_valid_q || a_out_ready;
  assign b_free  = !b_out_valid_q || b_out_ready;
  assign r_free  = !out_valid_q || out_ready;
  assign go      = a_free && b_free && (!a_last || r_free);
  assign a_ready = b_valid && go;
  assign b_ready = a_valid && go;
  assign fire    = a_valid && b_valid && go;

  logic [DATA_W-1:0] lane_a, lane_b;
  logic [SUM_W-1:0]  ext_a, ext_b, sum;

  // NOTE: every variable driven here gets a default before the loop so no latch is inferred.
  always_comb begin
    sum    = '0;
    lane_a = '0;
    lane_b = '0;
    ext_a  = '0;
    ext_b  = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = a[i*DATA_W +: DATA_W];
      lane_b = b[i*DATA_W +: DATA_W];
      ext_a  = {{(SUM_W-DATA_W){SGN & lane_a[DATA_W-1]}}, lane_a};
      ext_b  = {{(SUM_W-DATA_W){SGN & lane_b[DATA_W-1]}}, lane_b};
      sum    = sum + ext_a * ext_b;
    end
  end

  // One guard bit above the wider operand makes the addition exact in either mode.
  logic [EXT_W-1:0]     acc_ext, sum_ext, nxt;
  logic [EXT_W-ACC_W:0] nxt_top;
  logic                 ovf;
  logic [ACC_W-1:0]     res;
  logic [CNT_W-1:0]     cnt_inc;

  assign acc_ext = {{(EXT_W-ACC_W){SGN & acc_q[ACC_W-1]}}, acc_q};
  assign sum_ext = {{(EXT_W-SUM_W){SGN & sum[SUM_W-1]}}, sum};
  assign nxt     = acc_ext + sum_ext;
  assign nxt_top = nxt[EXT_W-1:ACC_W-1];
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    if (SGN) ovf = (nxt_top != '0) && (nxt_top != '1);
    else     ovf = |nxt_top[EXT_W-ACC_W:1];
    res = nxt[ACC_W-1:0];
    if (SAT && ovf) res = (SGN && nxt[EXT_W-1]) ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    a_out_d       = a_out_q;
    a_out_last_d  = a_out_last_q;
    a_out_valid_d = a_out_valid_q && !a_out_ready;
    b_out_d       = b_out_q;
    b_out_valid_d = b_out_valid_q && !b_out_ready;
    acc_d         = acc_q;
    sat_d         = sat_q;
    cnt_d         = cnt_q;
    out_d         = out_q;
    out_beats_d   = out_beats_q;
    out_sat_d     = out_sat_q;
    out_valid_d   = out_valid_q && !out_ready;
    if (fire) begin
      a_out_d       = a;
      a_out_last_d  = a_last;
      a_out_valid_d = 1'b1;
      b_out_d       = b;
      b_out_valid_d = 1'b1;
      if (a_last) begin
        out_d       = res;
        out_beats_d = cnt_inc;
        out_sat_d   = sat_q | ovf;
        out_valid_d = 1'b1;
        acc_d       = '0;
        sat_d       = 1'b0;
        cnt_d       = '0;
      end else begin
        acc_d = res;
        sat_d = sat_q | ovf;
        cnt_d = cnt_inc;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out_q       <= '0;
      a_out_last_q  <= 1'b0;
      a_out_valid_q <= 1'b0;
      b_out_q       <= '0;
      b_out_valid_q <= 1'b0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      cnt_q         <= '0;
      out_q         <= '0;
      out_beats_q   <= '0;
      out_sat_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      a_out_q       <= a_out_d;
      a_out_last_q  <= a_out_last_d;
      a_out_valid_q <= a_out_valid_d;
      b_out_q       <= b_out_d;
      b_out_valid_q <= b_out_valid_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      out_beats_q   <= out_beats_d;
      out_sat_q     <= out_sat_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign a_out       = a_out_q;
  assign a_out_last  = a_out_last_q;
  assign a_out_valid = a_out_valid_q;
  assign b_out       = b_out_q;
  assign b_out_valid = b_out_valid_q;
  assign out         = out_q;
  assign out_beats   = out_beats_q;
  assign out_sat     = out_sat_q;
  assign out_valid   = out_valid_q;

endmodule
